aes_subbytes_sched: RTL
=======================

Name: aes_subbytes_sched

Overview:
- Time-shares a small bank of `aes_sbox` lanes between two requesters.
- Requester 1 is the round datapath: a 128-bit SubBytes over the full state.
- Requester 2 is the key expansion: a 32-bit SubWord.
- The block sits between the round controller and the key scheduler, so the core carries LANES S-box instances instead of 20.
- It accepts one job at a time, processes LANES bytes per cycle, and holds the result until the requester accepts it.

Parameters:
- LANES, 4, number of S-box instances; legal values 1, 2 and 4; any other value is an elaboration error.
- ST_BEATS, 16/LANES, derived; beats per state job.
- KW_BEATS, 4/LANES, derived; beats per key-word job.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- st_in_valid  in  1  state job offered.
- st_in_ready  out  1  state job accepted when both st_in_valid and st_in_ready are high.
- st_in_data  in  128  state; byte i = bits [8i+7:8i].
- st_out_valid  out  1  substituted state available.
- st_out_ready  in  1  consumer accepts the state result.
- st_out_data  out  128  substituted state.
- kw_in_valid  in  1  key-word job offered.
- kw_in_ready  out  1  key-word job accepted when both kw_in_valid and kw_in_ready are high.
- kw_in_data  in  32  word; byte i = bits [8i+7:8i].
- kw_out_valid  out  1  substituted word available.
- kw_out_ready  in  1  consumer accepts the word result.
- kw_out_data  out  32  substituted word.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Every output is 0.
  - FSM goes to IDLE.
  - Round-robin pointer is set to favour KW.
  - The data registers are cleared.
  - Assertion mid-job aborts the job immediately; no partial result is ever presented.
- FSM states: IDLE, ST_RUN, KW_RUN, ST_HOLD, KW_HOLD.
- IDLE:
  - st_in_ready and kw_in_ready are combinationally high only in IDLE, and only for the requester that wins arbitration this cycle.
  - Only one requester is granted per cycle.
  - One valid requester: that requester is granted.
  - Both valid: round-robin. The requester not granted last wins; after reset, KW wins.
  - The pointer updates only on an accepted handshake.
- Accept at cycle t:
  - The input is captured into the working register.
  - Beat counter is set to 0.
  - FSM moves to ST_RUN or KW_RUN.
- RUN (beat k, cycles t+1 .. t+BEATS):
  - Lane j substitutes byte k*LANES+j.
  - The result byte is written into the result register at the same position.
  - After the last beat, FSM moves to the matching HOLD state.
- HOLD:
  - The matching out_valid is high and out_data is stable.
  - An output handshake returns the FSM to IDLE.
  - A new job is accepted no earlier than the cycle after that handshake.
  - No back-to-back overlap.
- Latency:
  - st_out_valid rises at cycle t+1+ST_BEATS (t+5 for LANES=4).
  - kw_out_valid rises at t+1+KW_BEATS (t+2 for LANES=4).
- Output validity:
  - out_valid stays high until the handshake, with data unchanged.
  - After the handshake, out_valid drops to 0 and out_data holds its last value.
- Lanes not driven in a beat:
  - The lane input mux selects byte 0.
  - Those outputs are ignored.
- Input changes:
  - Changes on in_data after acceptance have no effect.
  - An in_valid that drops before acceptance is legal.
- Simultaneous events:
  - A valid on the losing requester simply waits.
  - The round-robin pointer prevents either requester from starving another.

Optional Feature:
- Macro: AES_SBOX_SCHED_INV_EN.
- Defined:
  - Adds input port st_in_inv (1 bit), sampled at acceptance.
  - Each lane also instantiates aes_inv_sbox, and a per-lane mux selects the inverse output for state jobs with inv=1 (InvSubBytes).
  - Key-word jobs always use the forward S-box.
- Undefined:
  - The port is absent and no inverse tables are instantiated.

Decomposition:
- Package aes_pkg:
  - AES_BLOCK_BYTES=16 and AES_WORD_BYTES=4.
  - Scheduler state enum typedef sched_state_t.
  - Requester id typedef req_id_t (ST/KW).
- Sub-module aes_sbox_lane:
  - Wraps one aes_sbox, plus one aes_inv_sbox and the output mux under the macro.
  - Generated LANES times.
  - Control, arbitration and byte steering stay in the top module.

Test Plan:
- State all 8'h00, LANES=4 → st_out_data = all 8'h63; st_out_valid exactly 5 cycles after accept; busy high cycles t+1..t+5.
- kw_in_data = 32'hcf4f3c09 → kw_out_data = 32'h8a84eb01 at t+2; a held-low kw_out_ready for 10 cycles keeps data and valid stable, and st_in_ready stays 0 throughout.
- Both requesters valid continuously from reset → grant order is KW, ST, KW, ST.
- State bytes 8'h53 and 8'hff in positions 0 and 15 → outputs 8'hed and 8'h16 in the same positions; run under LANES=1, 2 and 4 with latencies 17, 9 and 5.
- rst_n pulsed low during ST_RUN beat 2 → all outputs 0 asynchronously; after release, no st_out_valid; a fresh job completes correctly.
- With AES_SBOX_SCHED_INV_EN and st_in_inv=1, state all 8'h63 → all 8'h00; a KW job issued next still uses the forward S-box.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the S-box scheduler: sizes, scheduler state,
// requester ids and the GF(2^8) helpers behind the forward/inverse S-box.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_WORD_BYTES  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_RUN  = 3'd1,
        KW_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        KW_HOLD = 3'd4
    } sched_state_t;

    typedef enum logic {
        REQ_ST = 1'b0,
        REQ_KW = 1'b1
    } req_id_t;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward S-box: inverse followed by the affine transform.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse.
    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] y;
        y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, one byte in, one byte out, purely combinational.
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_pkg::*;

    assign out_byte = sbox_inv(in_byte);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in, one byte out, purely combinational.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_pkg::*;

    assign out_byte = sbox_fwd(in_byte);

endmodule

// File: rtl/aes_sbox_lane.sv
// One substitution lane of the scheduler. With AES_SBOX_SCHED_INV_EN defined
// the lane also carries an inverse S-box and picks it when inv is high.
module aes_sbox_lane (
    input  logic [7:0] in_byte,
`ifdef AES_SBOX_SCHED_INV_EN
    input  logic       inv,
`endif
    output logic [7:0] out_byte
);

    logic [7:0] fwd_byte;

    aes_sbox u_fwd (
        .in_byte  (in_byte),
        .out_byte (fwd_byte)
    );

`ifdef AES_SBOX_SCHED_INV_EN
    logic [7:0] inv_byte;

    aes_inv_sbox u_inv (
        .in_byte  (in_byte),
        .out_byte (inv_byte)
    );

    assign out_byte = inv ? inv_byte : fwd_byte;
`else
    assign out_byte = fwd_byte;
`endif

endmodule

// File: rtl/aes_subbytes_sched.sv
// Time-shared SubBytes/SubWord engine: LANES S-box lanes serve the round
// datapath (128-bit state) and the key expansion (32-bit word), one job at a
// time, round-robin between them. Optional InvSubBytes support for state jobs
// is enabled with the AES_SBOX_SCHED_INV_EN macro (adds port st_in_inv).
module aes_subbytes_sched #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in_data,
`ifdef AES_SBOX_SCHED_INV_EN
    input  logic         st_in_inv,
`endif
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         kw_in_valid,
    output logic         kw_in_ready,
    input  logic [31:0]  kw_in_data,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out_data,
    output logic         busy
);
    import aes_pkg::*;

    localparam int ST_BEATS = AES_BLOCK_BYTES / LANES;
    localparam int KW_BEATS = AES_WORD_BYTES / LANES;
    localparam logic [3:0] ST_LAST = 4'(ST_BEATS - 1);
    localparam logic [3:0] KW_LAST = 4'(KW_BEATS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("aes_subbytes_sched: LANES must be 1, 2 or 4");
        end
    endgenerate

    sched_state_t state;
    req_id_t      rr_next;
    logic [3:0]   beat;
    logic [127:0] work;
    logic [127:0] st_res;
    logic [31:0]  kw_res;
    logic         grant_st;
    logic         grant_kw;
    logic [3:0]   lane_idx [LANES];
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];

`ifdef AES_SBOX_SCHED_INV_EN
    logic inv_q;
    logic lane_inv;

    assign lane_inv = inv_q && (state == ST_RUN);
`endif

    // Arbitration: grant at most one requester, only in IDLE and out of reset.
    always_comb begin
        grant_st = 1'b0;
        grant_kw = 1'b0;
        if (rst_n && state == IDLE) begin
            if (st_in_valid && kw_in_valid) begin
                grant_kw = (rr_next == REQ_KW);
                grant_st = (rr_next == REQ_ST);
            end else begin
                grant_st = st_in_valid;
                grant_kw = kw_in_valid;
            end
        end
    end

    assign st_in_ready  = grant_st;
    assign kw_in_ready  = grant_kw;
    assign busy         = (state != IDLE);
    assign st_out_valid = (state == ST_HOLD);
    assign kw_out_valid = (state == KW_HOLD);
    assign st_out_data  = st_res;
    assign kw_out_data  = kw_res;

    // Byte steering: lane j works on byte beat*LANES+j while running, byte 0 otherwise.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_idx[j] = beat * 4'(LANES) + 4'(j);
            lane_in[j]  = work[7:0];
            if (state == ST_RUN || state == KW_RUN) begin
                lane_in[j] = work[{lane_idx[j], 3'b000} +: 8];
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
`ifdef AES_SBOX_SCHED_INV_EN
        aes_sbox_lane u_lane (
            .in_byte  (lane_in[j]),
            .inv      (lane_inv),
            .out_byte (lane_out[j])
        );
`else
        aes_sbox_lane u_lane (
            .in_byte  (lane_in[j]),
            .out_byte (lane_out[j])
        );
`endif
    end

    // Scheduler FSM: accept, run the beats into the result register, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_next <= REQ_KW;
            beat    <= 4'd0;
            work    <= '0;
            st_res  <= '0;
            kw_res  <= '0;
`ifdef AES_SBOX_SCHED_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_st) begin
                        work    <= st_in_data;
                        beat    <= 4'd0;
                        rr_next <= REQ_KW;
                        state   <= ST_RUN;
`ifdef AES_SBOX_SCHED_INV_EN
                        inv_q   <= st_in_inv;
`endif
                    end else if (grant_kw) begin
                        work    <= {96'd0, kw_in_data};
                        beat    <= 4'd0;
                        rr_next <= REQ_ST;
                        state   <= KW_RUN;
                    end
                end
                ST_RUN: begin
                    for (int j = 0; j < LANES; j++) begin
                        st_res[{lane_idx[j], 3'b000} +: 8] <= lane_out[j];
                    end
                    beat <= beat + 4'd1;
                    if (beat == ST_LAST) state <= ST_HOLD;
                end
                KW_RUN: begin
                    for (int j = 0; j < LANES; j++) begin
                        kw_res[{lane_idx[j][1:0], 3'b000} +: 8] <= lane_out[j];
                    end
                    beat <= beat + 4'd1;
                    if (beat == KW_LAST) state <= KW_HOLD;
                end
                ST_HOLD: begin
                    if (st_out_ready) state <= IDLE;
                end
                KW_HOLD: begin
                    if (kw_out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
